mmio_led_ctrl: RTL and testbench
================================

Name: mmio_led_ctrl

Overview:
Parametrised memory-mapped LED output peripheral on the processor data/address bus. It generalises the single LEDR register: configurable output width and base address, atomic set/clear registers, and a per-bit hardware blink engine driven by a programmable down-counter. The output vector drives board LEDs directly. Reads return register contents one cycle after the address is presented.

Parameters:
BASE_ADDR, 32'hF0000000, byte address of register 0; registers sit at BASE_ADDR + 4*n.
WIDTH, 10, number of LED outputs (1..32); all register data is masked to WIDTH bits.
PERIOD_W, 24, width of the blink period register and counter (1..32).

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
dbus  input  32  write data
abus  input  32  byte address
wren  input  1  write enable; when low the cycle is a read
value  output  WIDTH  LED drive vector
dbusout  output  32  registered read data; zero when not addressed

Behaviour:
- Register map (offset: name, access):
  - 0x0: DATA, RW.
  - 0x4: SET, W1S on DATA; reads DATA.
  - 0x8: CLR, W1C on DATA; reads DATA.
  - 0xC: BLINK, RW mask.
  - 0x10: PERIOD, RW, PERIOD_W bits.
  - 0x14: STATUS, RO; bit0 = phase, bits[31:1] = 0.
- Decoding is an exact 32-bit address compare. Unmapped addresses are ignored on write and read as 0.
- Reset (async, reset_n=0): DATA=0, BLINK=0, PERIOD=0, cnt=0, phase=1, dbusout=0. value is therefore 0.
- Write cycle (wren=1):
  - Addressed register updates at the rising edge with dbus masked to its width.
  - SET: DATA |= dbus[WIDTH-1:0]. CLR: DATA &= ~dbus[WIDTH-1:0].
  - Writes to STATUS and unmapped addresses have no effect.
  - dbusout <= 0 on every write cycle.
- Read cycle (wren=0): dbusout <= zero-extended register contents at the next edge if abus matches a mapped register, otherwise 0. Read latency is 1 cycle. Reads have no side effects.
- Blink engine:
  - PERIOD==0: engine disabled; phase held at 1, cnt held at 0.
  - PERIOD!=0: cnt decrements by 1 each cycle. When cnt==0, cnt <= PERIOD and phase toggles. Half-period is therefore PERIOD+1 cycles.
  - A write to PERIOD sets cnt <= new value and phase <= 1 on the same edge. This write takes priority over a simultaneous expiry (no toggle that cycle).
  - A write of 0 to PERIOD stops the engine with phase=1.
- Output: value = DATA & (~BLINK | {WIDTH{phase}}).
  - value is combinational from the registers, so it has no extra latency: changes appear at the edge after the write.
  - Bits with BLINK=0 follow DATA steadily. Bits with BLINK=1 and DATA=1 flash. Bits with DATA=0 are always off.
- SET/CLR writes and counter expiry in the same cycle are independent: both take effect.
- Mid-operation reset returns all state to reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package holds:
  - register offset constants (OFF_DATA=0x0, OFF_SET=0x4, OFF_CLR=0x8, OFF_BLINK=0xC, OFF_PERIOD=0x10, OFF_STATUS=0x14);
  - a function returning the WIDTH mask.
- One sub-module, blink_timer: inputs PERIOD, load strobe, clk, reset_n; outputs phase. It contains cnt and phase and the priority rule above.
- Decode, register bank and read mux stay in the top module.

Test Plan:
- Reset: assert reset_n=0 mid-cycle with DATA=0x3FF -> value=0 and dbusout=0 immediately; read STATUS after release -> 0x1.
- Write DATA 0xFFFFFFFF at BASE+0 (WIDTH=10) -> value=0x3FF; next-cycle read of BASE+0 returns 0x000003FF one cycle later. Read BASE+0x18 -> 0.
- SET 0x005 then CLR 0x001 starting from DATA=0x100 -> DATA 0x105 then 0x104. A read of SET returns 0x104.
- BLINK=0x00F, DATA=0x0FF, PERIOD=3 -> value alternates 0x0FF / 0x0F0 every 4 cycles, starting with 0x0FF for 4 cycles after the PERIOD write.
- Write PERIOD=5 on the exact cycle cnt==0 -> phase stays 1 (no toggle), next toggle 6 cycles later. Write PERIOD=0 while phase=0 -> phase=1, value=DATA.
- WIDTH=32, PERIOD_W=8 instance: DATA=0xDEADBEEF reads back unmasked; PERIOD write 0x1FF stores 0xFF.

Source files
------------

// File: rtl/mmio_led_ctrl_pkg.sv
// Shared constants and helpers for the memory-mapped LED controller.
package mmio_led_ctrl_pkg;

  localparam int unsigned BUS_W = 32;

  // Register byte offsets relative to BASE_ADDR
  localparam logic [BUS_W-1:0] OFF_DATA   = 32'h0000_0000;
  localparam logic [BUS_W-1:0] OFF_SET    = 32'h0000_0004;
  localparam logic [BUS_W-1:0] OFF_CLR    = 32'h0000_0008;
  localparam logic [BUS_W-1:0] OFF_BLINK  = 32'h0000_000C;
  localparam logic [BUS_W-1:0] OFF_PERIOD = 32'h0000_0010;
  localparam logic [BUS_W-1:0] OFF_STATUS = 32'h0000_0014;

  // Mask with the low w bits set (w saturates at the bus width)
  function automatic logic [BUS_W-1:0] width_mask(input int unsigned w);
    if (w >= BUS_W) begin
      return {BUS_W{1'b1}};
    end
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/mmio_led_ctrl_blink_timer.sv
// Blink phase generator: reloading down-counter that toggles phase on expiry.
module mmio_led_ctrl_blink_timer #(
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic                i_load,
  input  logic [PERIOD_W-1:0] i_load_val,
  output logic                o_phase
);

  logic [PERIOD_W-1:0] r_cnt;
  logic                r_phase;

  // Counter/phase update; a PERIOD write beats a simultaneous expiry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (i_load) begin
      r_cnt   <= i_load_val;
      r_phase <= 1'b1;
    end else if (i_period == '0) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (r_cnt == '0) begin
      r_cnt   <= i_period;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt - PERIOD_W'(1);
    end
  end

  assign o_phase = r_phase;

endmodule

// File: rtl/mmio_led_ctrl.sv
// Memory-mapped LED peripheral: DATA/SET/CLR/BLINK/PERIOD/STATUS registers.
module mmio_led_ctrl
  import mmio_led_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hF000_0000,
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned PERIOD_W  = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      dbus,
  input  logic [31:0]      abus,
  input  logic             wren,
  output logic [WIDTH-1:0] value,
  output logic [31:0]      dbusout
);

  localparam logic [31:0] A_DATA   = BASE_ADDR + OFF_DATA;
  localparam logic [31:0] A_SET    = BASE_ADDR + OFF_SET;
  localparam logic [31:0] A_CLR    = BASE_ADDR + OFF_CLR;
  localparam logic [31:0] A_BLINK  = BASE_ADDR + OFF_BLINK;
  localparam logic [31:0] A_PERIOD = BASE_ADDR + OFF_PERIOD;
  localparam logic [31:0] A_STATUS = BASE_ADDR + OFF_STATUS;

  logic [WIDTH-1:0]    r_data;
  logic [WIDTH-1:0]    r_blink;
  logic [PERIOD_W-1:0] r_period;
  logic [31:0]         r_dbusout;

  logic                w_sel_data;
  logic                w_sel_set;
  logic                w_sel_clr;
  logic                w_sel_blink;
  logic                w_sel_period;
  logic                w_sel_status;
  logic                w_phase;
  logic [WIDTH-1:0]    w_wdata;
  logic [31:0]         w_rdata;

  // Exact address decode
  assign w_sel_data   = (abus == A_DATA);
  assign w_sel_set    = (abus == A_SET);
  assign w_sel_clr    = (abus == A_CLR);
  assign w_sel_blink  = (abus == A_BLINK);
  assign w_sel_period = (abus == A_PERIOD);
  assign w_sel_status = (abus == A_STATUS);

  assign w_wdata = WIDTH'(dbus);

  // Register bank writes, data masked to each register's width
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data   <= '0;
      r_blink  <= '0;
      r_period <= '0;
    end else if (wren) begin
      if (w_sel_data)   r_data   <= w_wdata;
      if (w_sel_set)    r_data   <= r_data | w_wdata;
      if (w_sel_clr)    r_data   <= r_data & ~w_wdata;
      if (w_sel_blink)  r_blink  <= w_wdata;
      if (w_sel_period) r_period <= PERIOD_W'(dbus);
    end
  end

  // Read mux; SET and CLR alias DATA on read, unmapped reads as zero
  always_comb begin
    w_rdata = '0;
    if (w_sel_data || w_sel_set || w_sel_clr) begin
      w_rdata = 32'(r_data) & width_mask(WIDTH);
    end else if (w_sel_blink) begin
      w_rdata = 32'(r_blink) & width_mask(WIDTH);
    end else if (w_sel_period) begin
      w_rdata = 32'(r_period) & width_mask(PERIOD_W);
    end else if (w_sel_status) begin
      w_rdata = {31'd0, w_phase};
    end
  end

  // Registered read data, cleared on write cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dbusout <= '0;
    end else if (wren) begin
      r_dbusout <= '0;
    end else begin
      r_dbusout <= w_rdata;
    end
  end

  mmio_led_ctrl_blink_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_blink_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_period   (r_period),
    .i_load     (wren && w_sel_period),
    .i_load_val (PERIOD_W'(dbus)),
    .o_phase    (w_phase)
  );

  // Blinking bits are gated by phase; non-blinking bits follow DATA
  assign value   = r_data & (~r_blink | {WIDTH{w_phase}});
  assign dbusout = r_dbusout;

endmodule

// File: tb/tb_mmio_led_ctrl.sv
// Randomized self-checking bench for mmio_led_ctrl against a cycle-count model.
module tb_mmio_led_ctrl;

  localparam logic [31:0] BASE  = 32'hF000_0000;
  localparam logic [31:0] LMASK = 32'h0000_03FF;
  localparam logic [31:0] PMASK = 32'h00FF_FFFF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] dbus, abus, dbusout;
  logic        wren;
  logic [9:0]  value;

  logic [31:0] dbus2, abus2, dbusout2, value2;
  logic        wren2;

  always #5 clk = ~clk;

  mmio_led_ctrl #(.BASE_ADDR(BASE), .WIDTH(10), .PERIOD_W(24)) u_dut (
    .clk(clk), .reset_n(reset_n), .dbus(dbus), .abus(abus), .wren(wren),
    .value(value), .dbusout(dbusout)
  );

  mmio_led_ctrl #(.BASE_ADDR(BASE), .WIDTH(32), .PERIOD_W(8)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .dbus(dbus2), .abus(abus2), .wren(wren2),
    .value(value2), .dbusout(dbusout2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: phase derived from edges elapsed since the last PERIOD write
  logic [31:0] m_data, m_blink, m_per, m_rd;
  longint      m_t0, edge_n;

  task automatic model_reset();
    m_data = 0; m_blink = 0; m_per = 0; m_rd = 0; m_t0 = edge_n;
  endtask

  function automatic logic m_phase(longint e);
    if (m_per == 0) return 1'b1;
    return (((e - m_t0) / (longint'(m_per) + 1)) % 2) == 0;
  endfunction

  function automatic logic [31:0] m_value();
    logic [31:0] ph;
    ph = m_phase(edge_n) ? 32'hFFFF_FFFF : 32'h0;
    return m_data & (~m_blink | ph) & LMASK;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a)
      BASE + 32'h00, BASE + 32'h04, BASE + 32'h08: return m_data;
      BASE + 32'h0C: return m_blink;
      BASE + 32'h10: return m_per;
      BASE + 32'h14: return {31'd0, m_phase(edge_n)};
      default:       return 32'h0;
    endcase
  endfunction

  // One bus cycle on the WIDTH=10 instance, checked against the model
  task automatic cyc(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    wren = w; abus = a; dbus = d;
    @(posedge clk);
    rd = m_read(a);
    edge_n++;
    if (w) begin
      m_rd = 0;
      case (a)
        BASE + 32'h00: m_data  = d & LMASK;
        BASE + 32'h04: m_data  = m_data | (d & LMASK);
        BASE + 32'h08: m_data  = m_data & ~(d & LMASK);
        BASE + 32'h0C: m_blink = d & LMASK;
        BASE + 32'h10: begin m_per = d & PMASK; m_t0 = edge_n; end
        default: ;
      endcase
    end else begin
      m_rd = rd;
    end
    #1;
    check_val("value", 32'(value), m_value());
    check_val("dbusout", dbusout, m_rd);
  endtask

  task automatic cyc32(input logic w, input logic [31:0] a, input logic [31:0] d);
    wren2 = w; abus2 = a; dbus2 = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    edge_n  = 0;
    reset_n = 1'b0;
    wren = 0; abus = 0; dbus = 0;
    wren2 = 0; abus2 = 0; dbus2 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_value", 32'(value), 32'h0);
    check_val("rst_dbusout", dbusout, 32'h0);
    check_val("rst_value32", value2, 32'h0);
    #2 reset_n = 1'b1;

    // Full-width write is masked; read latency one cycle; unmapped read is zero
    cyc(1, BASE, 32'hFFFF_FFFF);
    check_val("data_all", 32'(value), 32'h3FF);
    cyc(0, BASE, 0);
    check_val("read_data", dbusout, 32'h3FF);
    cyc(0, BASE + 32'h18, 0);
    check_val("read_unmapped", dbusout, 32'h0);

    // Asynchronous reset in mid-cycle
    cyc(0, BASE, 0);
    #2 reset_n = 1'b0;
    #1;
    check_val("async_rst_value", 32'(value), 32'h0);
    check_val("async_rst_dbusout", dbusout, 32'h0);
    model_reset();
    @(posedge clk);
    #3 reset_n = 1'b1;
    cyc(0, BASE + 32'h14, 0);
    check_val("status_after_rst", dbusout, 32'h1);

    // SET / CLR
    cyc(1, BASE, 32'h100);
    cyc(1, BASE + 32'h04, 32'h005);
    check_val("set", 32'(value), 32'h105);
    cyc(1, BASE + 32'h08, 32'h001);
    check_val("clr", 32'(value), 32'h104);
    cyc(0, BASE + 32'h04, 0);
    check_val("read_set", dbusout, 32'h104);

    // Blink with PERIOD=3: four cycles on, four off
    cyc(1, BASE, 32'h0FF);
    cyc(1, BASE + 32'h0C, 32'h00F);
    cyc(1, BASE + 32'h10, 32'd3);
    check_val("blink_start", 32'(value), 32'h0FF);
    for (int i = 1; i < 12; i++) begin
      cyc(0, BASE + 32'h14, 0);
      check_val("blink_seq", 32'(value), ((i / 4) % 2 == 0) ? 32'h0FF : 32'h0F0);
    end

    // PERIOD write on the expiry edge wins: no toggle, next toggle 6 cycles later
    cyc(1, BASE + 32'h10, 32'd3);
    for (int i = 1; i < 4; i++) cyc(0, BASE, 0);
    cyc(1, BASE + 32'h10, 32'd5);
    check_val("prio_no_toggle", 32'(value), 32'h0FF);
    for (int i = 1; i < 6; i++) begin
      cyc(0, BASE, 0);
      check_val("prio_hold", 32'(value), 32'h0FF);
    end
    cyc(0, BASE, 0);
    check_val("prio_toggle", 32'(value), 32'h0F0);
    cyc(1, BASE + 32'h10, 32'd0);
    check_val("period0_value", 32'(value), 32'h0FF);
    cyc(0, BASE + 32'h14, 0);
    check_val("period0_status", dbusout, 32'h1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int unsigned r;
      logic [31:0] a, d;
      r = $urandom_range(0, 7);
      if (r < 6)       a = BASE + 32'(r * 4);
      else if (r == 6) a = BASE + 32'h18;
      else             a = $urandom;
      d = $urandom;
      if (r == 4) d = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 6));
      cyc(($urandom_range(0, 2) == 0), a, d);
    end

    // WIDTH=32, PERIOD_W=8 instance
    cyc32(1, BASE, 32'hDEAD_BEEF);
    check_val("w32_value", value2, 32'hDEAD_BEEF);
    cyc32(0, BASE, 0);
    check_val("w32_read", dbusout2, 32'hDEAD_BEEF);
    cyc32(1, BASE + 32'h10, 32'h1FF);
    cyc32(0, BASE + 32'h10, 0);
    check_val("w32_period", dbusout2, 32'h0000_00FF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
